// File: rtl/instruction_dispatch_queue_pkg.sv
// -----------------------------------------------------------------------------
// instruction_dispatch_queue_pkg
// Shared decode definitions for the instruction dispatch queue:
//   - operaType op-type codes (3-bit) used to route the head entry
//   - TRUE / FALSE single-bit constants
//   - ISQ_DEFAULT_DEPTH, the default queue depth
//   - is_lsb_op(): true for op types that go to the load/store buffer
// -----------------------------------------------------------------------------
package instruction_dispatch_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int ISQ_DEFAULT_DEPTH = 16;
  localparam int OP_W              = 3;

  typedef enum logic [OP_W-1:0] {
    RType     = 3'd0,
    IType     = 3'd1,
    ILoadType = 3'd2,
    SType     = 3'd3,
    BType     = 3'd4,
    JALType   = 3'd5,
    JALRType  = 3'd6,
    UType     = 3'd7
  } opera_type_e;

  // Loads and stores are handled by the LSB; everything else goes to the RS.
  function automatic logic is_lsb_op(input logic [OP_W-1:0] op);
    return ((op == SType) || (op == ILoadType)) ? TRUE : FALSE;
  endfunction

endpackage

// File: rtl/isq_ring_buffer.sv
// -----------------------------------------------------------------------------
// isq_ring_buffer
// DEPTH-entry circular buffer with an occupancy counter so every slot is used.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   clr              : synchronous flush of head/rear/count (wins over enq/deq)
//   enq, enq_data    : write enq_data at rear this edge
//   deq              : retire the head entry this edge
//   head_data        : combinational read of the entry at head
//   count            : occupancy, 0..DEPTH
// The caller guarantees enq only when not full and deq only when not empty.
// -----------------------------------------------------------------------------
module isq_ring_buffer
  import instruction_dispatch_queue_pkg::*;
#(
  parameter int DEPTH  = ISQ_DEFAULT_DEPTH,
  parameter int W      = 67,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              clr,
  input  logic              enq,
  input  logic [W-1:0]      enq_data,
  input  logic              deq,
  output logic [W-1:0]      head_data,
  output logic [ADDR_W:0]   count
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] rear_q;
  logic [ADDR_W:0]   count_q;

  // Pointers wrap for free because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      head_q  <= '0;
      rear_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) rear_q <= rear_q + ADDR_W'(1);
      if (deq) head_q <= head_q + ADDR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until
  // written, and leaving it out of reset lets it map onto plain RAM/registers.
  always_ff @(posedge clk_in) begin
    if (enq && !clr) mem[rear_q] <= enq_data;
  end

  assign head_data = mem[head_q];
  assign count     = count_q;

endmodule

// File: rtl/instruction_dispatch_queue.sv
// -----------------------------------------------------------------------------
// instruction_dispatch_queue
// Buffers up to DEPTH decoded instructions between fetch/decode and the
// ROB/RS/LSB and dispatches the head with zero latency, one per cycle.
// Ports:
//   clk_in, rst_n_in             : clock, asynchronous active-low reset
//   rdy_in                       : global ready; low freezes the queue
//   roll_back                    : mispredict flush (empties queue next edge)
//   fetch_valid / fetch_ready    : enqueue handshake
//   instruction_in, pc_in, pc_predict_in, op_type_in : entry being offered
//   rob_is_full, rs_is_full, lsb_is_full : downstream back-pressure
//   ins_to_rob / ins_to_rs / ins_to_lsb  : dispatch fire strobes
//   instruction_out, ins_pc_out, pc_predict_out : head entry (0 when empty)
//   count, almost_full, is_empty : occupancy status
// Optional: define ISQ_PERF_CNT_EN to add saturating 32-bit stall_rob_cnt,
// stall_unit_cnt and empty_cnt performance counters.
// -----------------------------------------------------------------------------
module instruction_dispatch_queue
  import instruction_dispatch_queue_pkg::*;
#(
  parameter int DEPTH    = ISQ_DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INS_W    = 32,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [INS_W-1:0]  instruction_in,
  input  logic [INS_W-1:0]  pc_in,
  input  logic              pc_predict_in,
  input  logic [2:0]        op_type_in,
  input  logic              rob_is_full,
  input  logic              rs_is_full,
  input  logic              lsb_is_full,
  output logic              ins_to_rob,
  output logic              ins_to_rs,
  output logic              ins_to_lsb,
  output logic [INS_W-1:0]  instruction_out,
  output logic [INS_W-1:0]  ins_pc_out,
  output logic              pc_predict_out,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
`ifdef ISQ_PERF_CNT_EN
  output logic [31:0]       stall_rob_cnt,
  output logic [31:0]       stall_unit_cnt,
  output logic [31:0]       empty_cnt,
`endif
  output logic              is_empty
);

  localparam int ENTRY_W = INS_W*2 + 1 + OP_W;

  logic [ENTRY_W-1:0] head_data;
  logic [INS_W-1:0]   head_ins;
  logic [INS_W-1:0]   head_pc;
  logic               head_pred;
  logic [OP_W-1:0]    head_op;
  logic               to_lsb_head;
  logic               unit_full;
  logic               fire;
  logic               enq;
  logic               active;

  assign {head_ins, head_pc, head_pred, head_op} = head_data;

  assign is_empty    = (count == '0);
  assign active      = rdy_in & ~roll_back;
  // rst_n_in is folded in so fetch never sees ready while reset is held,
  // even though the cleared counter alone would look "not full".
  assign fetch_ready = rst_n_in & active & (count != (ADDR_W+1)'(DEPTH));
  assign enq         = fetch_valid & fetch_ready;
  assign almost_full = (count >= (ADDR_W+1)'(AF_LEVEL));

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    to_lsb_head = FALSE;
    unit_full   = FALSE;
    fire        = FALSE;
    ins_to_rob  = FALSE;
    ins_to_rs   = FALSE;
    ins_to_lsb  = FALSE;
    to_lsb_head = is_lsb_op(head_op);
    unit_full   = to_lsb_head ? lsb_is_full : rs_is_full;
    fire        = active & ~is_empty & ~rob_is_full & ~unit_full;
    ins_to_rob  = fire;
    ins_to_rs   = fire & ~to_lsb_head;
    ins_to_lsb  = fire & to_lsb_head;
  end

  // Storage is don't-care when empty; masking keeps the outputs at 0 then,
  // which also covers the all-zero requirement during reset.
  assign instruction_out = is_empty ? '0 : head_ins;
  assign ins_pc_out      = is_empty ? '0 : head_pc;
  assign pc_predict_out  = is_empty ? 1'b0 : head_pred;

  isq_ring_buffer #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_ring (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr       (roll_back),
    .enq       (enq),
    .enq_data  ({instruction_in, pc_in, pc_predict_in, op_type_in}),
    .deq       (fire),
    .head_data (head_data),
    .count     (count)
  );

`ifdef ISQ_PERF_CNT_EN
  logic stall_rob_ev;
  logic stall_unit_ev;
  logic empty_ev;

  assign stall_rob_ev  = active & ~is_empty & rob_is_full;
  assign stall_unit_ev = active & ~is_empty & ~rob_is_full & unit_full;
  assign empty_ev      = rdy_in & is_empty;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_rob_cnt  <= '0;
      stall_unit_cnt <= '0;
      empty_cnt      <= '0;
    end else begin
      if (stall_rob_ev  && (stall_rob_cnt  != '1)) stall_rob_cnt  <= stall_rob_cnt  + 32'd1;
      if (stall_unit_ev && (stall_unit_cnt != '1)) stall_unit_cnt <= stall_unit_cnt + 32'd1;
      if (empty_ev      && (empty_cnt      != '1)) empty_cnt      <= empty_cnt      + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_dispatch_queue
// Self-checking bench: a queue-of-entries reference model decides what should
// dispatch each cycle and pushes it into a scoreboard; a separate monitor pops
// and compares whenever the DUT fires. Directed scenarios are followed by a
// long randomized run.
// -----------------------------------------------------------------------------
module tb_instruction_dispatch_queue;
  import instruction_dispatch_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int INS_W = 32;
  localparam int AF    = DEPTH - 2;

  logic              clk_in;
  logic              rst_n_in;
  logic              rdy_in;
  logic              roll_back;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [INS_W-1:0]  instruction_in;
  logic [INS_W-1:0]  pc_in;
  logic              pc_predict_in;
  logic [2:0]        op_type_in;
  logic              rob_is_full;
  logic              rs_is_full;
  logic              lsb_is_full;
  logic              ins_to_rob;
  logic              ins_to_rs;
  logic              ins_to_lsb;
  logic [INS_W-1:0]  instruction_out;
  logic [INS_W-1:0]  ins_pc_out;
  logic              pc_predict_out;
  logic [4:0]        count;
  logic              almost_full;
  logic              is_empty;
`ifdef ISQ_PERF_CNT_EN
  logic [31:0]       stall_rob_cnt;
  logic [31:0]       stall_unit_cnt;
  logic [31:0]       empty_cnt;
  int                m_stall_rob;
  int                m_stall_unit;
  int                m_empty;
`endif

  instruction_dispatch_queue #(.DEPTH(DEPTH), .INS_W(INS_W)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .roll_back       (roll_back),
    .fetch_valid     (fetch_valid),
    .fetch_ready     (fetch_ready),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .pc_predict_in   (pc_predict_in),
    .op_type_in      (op_type_in),
    .rob_is_full     (rob_is_full),
    .rs_is_full      (rs_is_full),
    .lsb_is_full     (lsb_is_full),
    .ins_to_rob      (ins_to_rob),
    .ins_to_rs       (ins_to_rs),
    .ins_to_lsb      (ins_to_lsb),
    .instruction_out (instruction_out),
    .ins_pc_out      (ins_pc_out),
    .pc_predict_out  (pc_predict_out),
    .count           (count),
    .almost_full     (almost_full),
`ifdef ISQ_PERF_CNT_EN
    .stall_rob_cnt   (stall_rob_cnt),
    .stall_unit_cnt  (stall_unit_cnt),
    .empty_cnt       (empty_cnt),
`endif
    .is_empty        (is_empty)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred;
    logic [2:0]  op;
  } ent_t;

  typedef struct {
    ent_t e;
    logic lsb;
  } disp_t;

  ent_t        mq[$];   // reference queue contents, oldest first
  disp_t       sb[$];   // expected dispatches awaiting the monitor
  int          total;
  int          bad;
  logic [31:0] pc_ctr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare settled outputs, advance model.
  task automatic cycle(input logic fv, input logic [2:0] op, input logic rob_f,
                       input logic rs_f, input logic lsb_f, input logic rdy,
                       input logic rb);
    ent_t e;
    int   n;
    logic lsb, exp_ready, exp_fire;
    @(negedge clk_in);
    e.ins  = $urandom;
    e.pc   = pc_ctr;
    e.pred = 1'($urandom_range(0, 1));
    e.op   = op;
    pc_ctr = pc_ctr + 32'd4;
    fetch_valid    = fv;
    instruction_in = e.ins;
    pc_in          = e.pc;
    pc_predict_in  = e.pred;
    op_type_in     = e.op;
    rob_is_full    = rob_f;
    rs_is_full     = rs_f;
    lsb_is_full    = lsb_f;
    rdy_in         = rdy;
    roll_back      = rb;
    #2;
    n         = mq.size();
    lsb       = (n != 0) && (mq[0].op == SType || mq[0].op == ILoadType);
    exp_ready = rdy && !rb && (n != DEPTH);
    exp_fire  = rdy && !rb && (n != 0) && !rob_f && (lsb ? !lsb_f : !rs_f);
    check("count", 64'(count), 64'(n));
    check("is_empty", 64'(is_empty), 64'(n == 0));
    check("almost_full", 64'(almost_full), 64'(n >= AF));
    check("fetch_ready", 64'(fetch_ready), 64'(exp_ready));
    check("fire_vec", 64'({ins_to_rob, ins_to_rs, ins_to_lsb}),
          64'({exp_fire, exp_fire && !lsb, exp_fire && lsb}));
`ifdef ISQ_PERF_CNT_EN
    check("stall_rob_cnt", 64'(stall_rob_cnt), 64'(m_stall_rob));
    check("stall_unit_cnt", 64'(stall_unit_cnt), 64'(m_stall_unit));
    check("empty_cnt", 64'(empty_cnt), 64'(m_empty));
    if (rdy && !rb && n != 0 && rob_f) m_stall_rob++;
    if (rdy && !rb && n != 0 && !rob_f && (lsb ? lsb_f : rs_f)) m_stall_unit++;
    if (rdy && n == 0) m_empty++;
`endif
    if (exp_fire) begin
      sb.push_back('{mq[0], lsb});
      void'(mq.pop_front());
    end
    if (fv && exp_ready) mq.push_back(e);
    if (rb) mq.delete();
  endtask

  // Asserts reset between edges, checks the immediate output state, releases.
  task automatic reset_pulse();
    @(negedge clk_in);
    fetch_valid = 1'b0;
    rdy_in      = 1'b1;
    roll_back   = 1'b0;
    rob_is_full = 1'b0;
    #1 rst_n_in = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_is_empty", 64'(is_empty), 64'd1);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_fires", 64'({ins_to_rob, ins_to_rs, ins_to_lsb}), 64'd0);
    check("rst_data", 64'({instruction_out, pc_predict_out}), 64'd0);
    check("rst_almost_full", 64'(almost_full), 64'd0);
    mq.delete();
    sb.delete();
`ifdef ISQ_PERF_CNT_EN
    m_stall_rob  = 0;
    m_stall_unit = 0;
    m_empty      = 0;
`endif
    @(negedge clk_in);
    rdy_in = 1'b0;  // keep the first post-reset edge idle
    #1 rst_n_in = 1'b1;
  endtask

  // Monitor: compares the head data against the scoreboard on every fire.
  initial begin
    forever begin
      @(negedge clk_in);
      #3;
      if (rst_n_in && ins_to_rob) begin
        if (sb.size() == 0) begin
          check("unexpected_fire", 64'(ins_to_rob), 64'd0);
        end else begin
          disp_t d;
          d = sb.pop_front();
          check("disp_ins", 64'(instruction_out), 64'(d.e.ins));
          check("disp_pc", 64'(ins_pc_out), 64'(d.e.pc));
          check("disp_pred", 64'(pc_predict_out), 64'(d.e.pred));
          check("disp_route", 64'({ins_to_rs, ins_to_lsb}), 64'({!d.lsb, d.lsb}));
        end
      end
    end
  end

  function automatic logic [2:0] rand_op();
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    pc_ctr = 32'h1000;
    rst_n_in = 1'b0;
    rdy_in = 1'b0; roll_back = 1'b0; fetch_valid = 1'b0;
    instruction_in = '0; pc_in = '0; pc_predict_in = 1'b0; op_type_in = '0;
    rob_is_full = 1'b0; rs_is_full = 1'b0; lsb_is_full = 1'b0;
`ifdef ISQ_PERF_CNT_EN
    m_stall_rob = 0; m_stall_unit = 0; m_empty = 0;
`endif
    reset_pulse();

    // Reset mid-stream after five enqueues held by a full ROB.
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_op(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_pulse();

    // Fill all 16 slots (ROB full), then two more offers that must be refused.
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, rand_op(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // Full queue with head dispatching: still no enqueue that cycle.
    cycle(1'b1, rand_op(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Streaming alternating ALU / store: one fire per cycle, count holds at 1.
    for (int i = 0; i < 20; i++)
      cycle(1'b1, (i % 2 == 0) ? RType : SType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Routing stall: load at head with LSB full and RS free, then release.
    cycle(1'b1, ILoadType, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, RType, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush at count=7 with a fetch offered in the flush cycle.
    for (int i = 0; i < 7; i++) cycle(1'b1, rand_op(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Pause: count=2, rdy_in low for 3 cycles with units free, then resume.
    for (int i = 0; i < 2; i++) cycle(1'b1, rand_op(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_op(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic, including pointer wrap many times over.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 99) < 70), rand_op(),
            ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 90),
            ($urandom_range(0, 99) < 3));

    // Drain with a bounded budget.
    for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++)
      cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, RType, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("model_drained", 64'(mq.size()), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
